instr_encoder: RTL and testbench

Program-loader block that is the inverse of the instruction decoder: it accepts symbolic instruction fields over a valid/ready handshake, packs them into 32-bit instruction words using this core's opcode map, and writes them sequentially into instruction memory through a registered write port. It sits between the test/boot host interface and the instruction memory, and runs before the CPU is released from reset. Illegal operations are rejected and counted, never written.

---
 rtl/instr_encoder.sv | 129 ++++++++++++
 tb/tb_instr_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Program loader: packs symbolic instruction fields into 32-bit words and
// streams them into instruction memory through a registered write port.
module instr_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  ptr;
    logic               xfer;
    logic               legal;
    logic [5:0]         funct;
    logic [31:0]        enc;

    assign xfer  = in_valid && in_ready;
    assign legal = (op <= 4'd8);

    always_comb begin
        funct = '0;
        case (op)
            4'd0:    funct = 6'd32;
            4'd1:    funct = 6'd34;
            4'd2:    funct = 6'd36;
            4'd3:    funct = 6'd37;
            4'd4:    funct = 6'd50;
            default: funct = '0;
        endcase
    end

    always_comb begin
        enc = '0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: enc = {6'd25, rs, rt, rd, 5'b0, funct};
            4'd5:    enc = {6'd47, rs, rt, imm};
            4'd6:    enc = {6'd48, rs, rt, imm};
            4'd7:    enc = {6'd49, rs, rt, imm};
            4'd8:    enc = {6'd2, target};
            default: enc = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // finish outranks start; the last legal accept at the top address closes the window
    always_comb begin
        state_next = state;
        if (finish) begin
            state_next = S_IDLE;
        end else if (start) begin
            state_next = S_LOAD;
        end else if (state == S_LOAD && xfer && legal && ptr == ADDR_W'(DEPTH - 1)) begin
            state_next = S_FULL;
        end
    end

    always_comb begin
        in_ready = (state == S_LOAD);
        full     = (state == S_FULL);
    end

    // A transfer accepted alongside start still writes; start then resets the session counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ptr       <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            mem_we <= xfer && legal;
            if (xfer && legal) begin
                mem_addr  <= ptr;
                mem_wdata <= enc;
            end
            if (start && !finish) begin
                ptr       <= '0;
                count     <= '0;
                err       <= 1'b0;
                err_count <= '0;
            end else if (xfer) begin
                if (legal) begin
                    ptr   <= ptr + ADDR_W'(1);
                    count <= count + (ADDR_W + 1)'(1);
                end else begin
                    err <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: fixed encoding table, hand-written
// session corner cases and randomized traffic against a behavioural model.
module tb_instr_encoder;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n, start, finish, in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full, err;
    logic [7:0]        err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: session open flag plus plain integer counters
    bit          m_open;
    int          m_count, m_errc;
    bit          m_err, m_we;
    int          m_addr;
    logic [31:0] m_wdata;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] word;
    } vec_t;

    vec_t tbl[9];

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs), .rt(rt),
        .rd(rd), .imm(imm), .target(target), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .full(full), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_word(input int o, input int s, input int t,
                                             input int d, input int i, input int tg);
        int opc[9] = '{25, 25, 25, 25, 25, 47, 48, 49, 2};
        int fn[5]  = '{32, 34, 36, 37, 50};
        logic [31:0] w;
        w = 32'(opc[o]) * 32'h0400_0000;
        if (o < 5)      w = w + 32'(s) * 32'h20_0000 + 32'(t) * 32'h1_0000 + 32'(d) * 32'h800 + 32'(fn[o]);
        else if (o < 8) w = w + 32'(s) * 32'h20_0000 + 32'(t) * 32'h1_0000 + 32'(i);
        else            w = w + 32'(tg);
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one edge using the inputs currently driven, then compare
    task automatic tick();
        bit rdy, xf, lg;
        rdy = m_open && (m_count < DEPTH);
        xf  = in_valid && rdy;
        lg  = (op <= 8);
        if (!rst_n) begin
            m_open = 0; m_count = 0; m_errc = 0; m_err = 0;
            m_we = 0; m_addr = 0; m_wdata = '0;
        end else begin
            m_we = xf && lg;
            if (m_we) begin
                m_addr  = m_count % DEPTH;
                m_wdata = ref_word(int'(op), int'(rs), int'(rt), int'(rd), int'(imm), int'(target));
                m_count++;
            end else if (xf) begin
                m_err  = 1;
                m_errc = (m_errc < 255) ? m_errc + 1 : 255;
            end
            if (finish) m_open = 0;
            else if (start) begin
                m_open = 1; m_count = 0; m_err = 0; m_errc = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("in_ready",  32'(in_ready),  32'(m_open && m_count < DEPTH));
        chk("full",      32'(full),      32'(m_open && m_count == DEPTH));
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", mem_wdata,      m_wdata);
        chk("count",     32'(count),     32'(m_count));
        chk("err",       32'(err),       32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_errc));
    endtask

    task automatic set_fields(input int o, input int s, input int t, input int d,
                              input int i, input int tg);
        op = 4'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i); target = 26'(tg);
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic rand_legal();
        set_fields($urandom_range(0, 8), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 2**26 - 1));
    endtask

    initial begin
        tbl[0] = '{4'd0, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0,  32'h6422_1820};
        tbl[1] = '{4'd4, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0,  32'h6422_1832};
        tbl[2] = '{4'd5, 5'd4, 5'd5, 5'd9, 16'h0010, 26'h0,  32'hBC85_0010};
        tbl[3] = '{4'd6, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0,  32'hC085_FFFC};
        tbl[4] = '{4'd7, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0,  32'hC485_0010};
        tbl[5] = '{4'd8, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h40, 32'h0800_0040};
        tbl[6] = '{4'd1, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0,  32'h6422_1822};
        tbl[7] = '{4'd2, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0,  32'h6422_1824};
        tbl[8] = '{4'd3, 5'd1, 5'd2, 5'd3, 16'h0,    26'h0,  32'h6422_1825};

        rst_n = 0; start = 0; finish = 0; in_valid = 0;
        set_fields(0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("reset_we", 32'(mem_we), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        rst_n = 1;
        tick();

        // Encoding table, back-to-back at consecutive addresses
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            set_fields(int'(tbl[i].op), int'(tbl[i].rs), int'(tbl[i].rt), int'(tbl[i].rd),
                       int'(tbl[i].imm), int'(tbl[i].target));
            in_valid = 1;
            tick();
            chk("tbl_we",   32'(mem_we),   32'd1);
            chk("tbl_addr", 32'(mem_addr), 32'(i));
            chk("tbl_word", mem_wdata,     tbl[i].word);
        end
        in_valid = 0;
        tick();
        chk("tbl_we_drop", 32'(mem_we), 32'd0);

        // Illegal op sandwiched between two ADDs
        pulse_start();
        in_valid = 1;
        set_fields(0, 1, 2, 3, 0, 0); tick();
        set_fields(12, 1, 2, 3, 0, 0); tick();
        chk("ill_no_we", 32'(mem_we), 32'd0);
        set_fields(0, 1, 2, 3, 0, 0); tick();
        chk("ill_addr1", 32'(mem_addr), 32'd1);
        in_valid = 0; tick();
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_errc", 32'(err_count), 32'd1);
        chk("ill_count", 32'(count), 32'd2);

        // Fill all words, then one extra offered word must be refused
        pulse_start();
        in_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rand_legal();
            tick();
        end
        chk("fill_last_addr", 32'(mem_addr), 32'(DEPTH - 1));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_count", 32'(count), 32'(DEPTH));
        rand_legal();
        tick();
        chk("fill_65_we", 32'(mem_we), 32'd0);
        in_valid = 0;
        finish = 1; tick(); finish = 0;
        chk("fin_keeps_count", 32'(count), 32'(DEPTH));
        chk("fin_full_clear", 32'(full), 32'd0);

        // Restart mid-session, then simultaneous start+finish
        pulse_start();
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin rand_legal(); tick(); end
        in_valid = 0;
        pulse_start();
        in_valid = 1; rand_legal(); tick(); in_valid = 0;
        chk("restart_addr", 32'(mem_addr), 32'd0);
        chk("restart_count", 32'(count), 32'd1);
        start = 1; finish = 1; tick(); start = 0; finish = 0;
        chk("sf_idle", 32'(in_ready), 32'd0);

        // Reset lands on the accepting edge: the pending write is discarded
        pulse_start();
        in_valid = 1; rand_legal(); tick();
        rst_n = 0; tick(); rst_n = 1; in_valid = 0;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        tick();

        // Randomized traffic with occasional control pulses
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) set_fields($urandom_range(0, 15), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
                    $urandom_range(0, 2**26 - 1));
            else rand_legal();
            start  = ($urandom_range(0, 49) == 0);
            finish = ($urandom_range(0, 89) == 0);
            rst_n  = ($urandom_range(0, 399) != 0);
            tick();
        end
        start = 0; finish = 0; in_valid = 0; rst_n = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
